frog_move_ctrl: RTL
===================

Name: frog_move_ctrl

Overview:
- Drives the move bus that every frog light cell listens to: the broadcast one-cycle L/R/U/D pulses, the spawn pulse and the grid-clear pulse.
- Turns raw key levels into single moves and tracks the frog position.
- Blocks moves that would leave the grid, so a lit cell is never switched off with no neighbour lit.
- Handles hit/respawn, lives, win at the top row, and score.

Parameters:
- COLS, 16, grid width in cells; x = 0 is the leftmost column.
- ROWS, 16, grid height in cells; y = 0 is the top (goal) row.
- START_X, 7, respawn column.
- START_Y, 15, respawn row.
- LIVES, 3, hits allowed before game over.
- REPEAT_CYCLES, 8, auto-repeat period in cycles; used only with AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low (asserted at 0).
- key_l, key_r, key_u, key_d  in  1 each  key levels, already synchronised, active-high.
- hit  in  1  collision level from the car logic.
- L, R, U, D  out  1 each  registered one-cycle move pulses to all cells.
- spawn  out  1  one-cycle pulse; lights the cell at (START_X, START_Y).
- clr  out  1  one-cycle pulse; clears all cells after a win.
- frog_x  out  $clog2(COLS)  current column.
- frog_y  out  $clog2(ROWS)  current row.
- score  out  8  win count, saturating at 255.
- lives  out  $clog2(LIVES+1)  lives remaining.
- game_over  out  1  level.

Behaviour:
- Reset (reset=0, asynchronous):
  - All pulse outputs = 0; game_over = 0.
  - frog_x = START_X, frog_y = START_Y, score = 0, lives = LIVES.
  - key_q = 0; state = SPAWN.
- Edge detect: key_q registers all four keys every cycle. A rising edge is key & ~key_q.
- Move latency: a key first sampled high at edge k gives its pulse during cycle k+1, for exactly one cycle.
- States:
  - SPAWN: spawn = 1 for one cycle; frog_x/frog_y load the start position; go to READY.
  - READY:
    - On any rising edge, choose one direction by priority U > D > L > R. Other simultaneous edges are discarded.
    - Boundary check: U needs frog_y > 0; D needs frog_y < ROWS-1; L needs frog_x > 0; R needs frog_x < COLS-1.
    - Allowed move: pulse that output and update position in the same registered update.
    - Blocked move: no pulse, position unchanged, the press is consumed.
    - A U move that lands on frog_y = 0 goes to WIN; any other move stays in READY.
  - WIN (one cycle):
    - win actions: clr = 1, score += 1 (saturating); go to SPAWN.
    - hit is ignored in this cycle.
  - DEAD:
    - Entered from READY or SPAWN on the first cycle hit = 1.
    - lives decrements once on entry; no pulses are issued.
    - Stays in DEAD while hit = 1.
    - On the first cycle with hit = 0: go to SPAWN if lives > 0, otherwise GAMEOVER.
  - GAMEOVER: game_over = 1; all keys and hit are ignored until reset.
- hit priority: in READY, hit overrides a same-cycle key edge and no move pulse is issued.
- Edges arriving in SPAWN, WIN, DEAD or GAMEOVER are discarded. A key held through SPAWN gives no move until it is released and pressed again.
- Reset mid-operation: immediate return to reset values. Any pulse in flight is dropped.
- Outputs are mutually exclusive: at most one of L/R/U/D/spawn/clr is high in any cycle.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- When defined:
  - A down-counter reloads to REPEAT_CYCLES on each accepted move.
  - While the accepted key stays high in READY, the same move repeats each time the counter expires, with the same boundary check.
  - Releasing the key, another key edge, hit, or leaving READY cancels the repeat.
- When undefined: exactly one move per rising edge; no counter is synthesised.

Test Plan:
- Release reset → spawn = 1 for exactly one cycle, frog = (7,15), lives = 3, score = 0, no L/R/U/D pulses.
- Press key_u and hold 5 cycles → U high for one cycle only, frog_y 15→14; key_u and key_l rising together → only U pulses.
- Press key_l at frog_x = 0, and key_d at frog_y = 15 → no pulse, position unchanged.
- Press U 15 times from (7,15) → the 15th U gives frog_y = 0; the next cycle has clr = 1 and score = 1; the cycle after that has spawn = 1 and frog = (7,15).
- hit for 3 cycles → lives 3→2, no pulses during hit, spawn the cycle after hit falls; repeat twice more → lives = 0, game_over = 1, keys ignored.
- With AUTO_REPEAT_EN and REPEAT_CYCLES = 4, hold key_r for 10 cycles from x = 7 → R pulses at cycles 1, 5 and 9, frog_x = 10.

Source files
------------

// File: rtl/frog_move_ctrl.sv
// Frog move-bus controller: key edge detection, boundary-checked moves, lives/score/win FSM.
// Optional auto-repeat of a held key is enabled with the AUTO_REPEAT_EN macro.
module frog_move_ctrl #(
  parameter int COLS          = 16,
  parameter int ROWS          = 16,
  parameter int START_X       = 7,
  parameter int START_Y       = 15,
  parameter int LIVES         = 3,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_l,
  input  logic                       key_r,
  input  logic                       key_u,
  input  logic                       key_d,
  input  logic                       hit,
  output logic                       L,
  output logic                       R,
  output logic                       U,
  output logic                       D,
  output logic                       spawn,
  output logic                       clr,
  output logic [$clog2(COLS)-1:0]    frog_x,
  output logic [$clog2(ROWS)-1:0]    frog_y,
  output logic [7:0]                 score,
  output logic [$clog2(LIVES+1)-1:0] lives,
  output logic                       game_over
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int LW = $clog2(LIVES+1);

  localparam logic [XW-1:0] X_MAX   = XW'(COLS-1);
  localparam logic [YW-1:0] Y_MAX   = YW'(ROWS-1);
  localparam logic [XW-1:0] X_START = XW'(START_X);
  localparam logic [YW-1:0] Y_START = YW'(START_Y);
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);
  localparam logic [XW-1:0] X_ZERO  = XW'(0);
  localparam logic [YW-1:0] Y_ZERO  = YW'(0);
  localparam logic [LW-1:0] L_INIT  = LW'(LIVES);
  localparam logic [LW-1:0] L_ONE   = LW'(1);
  localparam logic [LW-1:0] L_ZERO  = LW'(0);

  typedef enum logic [2:0] {
    ST_SPAWN = 3'd0,
    ST_READY = 3'd1,
    ST_WIN   = 3'd2,
    ST_DEAD  = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  state_e          r_state;
  logic [3:0]      r_key_q;
  logic            r_l, r_r, r_u, r_d, r_spawn, r_clr, r_game_over;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [7:0]      r_score;
  logic [LW-1:0]   r_lives;

  // Key vectors are ordered {U, D, L, R} so bit position encodes priority.
  logic [3:0]      w_keys;
  logic [3:0]      w_rise;
  logic [3:0]      w_sel;
  logic            w_allow;
  logic [XW-1:0]   w_nx;
  logic [YW-1:0]   w_ny;

  assign w_keys = {key_u, key_d, key_l, key_r};
  assign w_rise = w_keys & ~r_key_q;

`ifdef AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LOAD = RW'(REPEAT_CYCLES-1);
  localparam logic [RW-1:0] REP_ZERO = RW'(0);
  localparam logic [RW-1:0] REP_ONE  = RW'(1);

  logic            r_rep_act;
  logic [3:0]      r_rep_dir;
  logic [RW-1:0]   r_rep_cnt;
  logic            w_rep_held;
  logic            w_rep_fire;

  assign w_rep_held = |(w_keys & r_rep_dir);
  assign w_rep_fire = r_rep_act & w_rep_held & (r_rep_cnt == REP_ZERO) & ~(|w_rise);
`endif

  // Pick one requested direction: fresh edges by priority, else a due repeat.
  always_comb begin
    w_sel = 4'b0000;
    if (w_rise[3]) begin
      w_sel = 4'b1000;
    end else if (w_rise[2]) begin
      w_sel = 4'b0100;
    end else if (w_rise[1]) begin
      w_sel = 4'b0010;
    end else if (w_rise[0]) begin
      w_sel = 4'b0001;
    end
`ifdef AUTO_REPEAT_EN
    else if (w_rep_fire) begin
      w_sel = r_rep_dir;
    end
`endif
    else begin
      w_sel = 4'b0000;
    end
  end

  // Boundary check and candidate next position for the selected direction.
  always_comb begin
    w_allow = 1'b0;
    w_nx    = r_x;
    w_ny    = r_y;
    case (w_sel)
      4'b1000: begin
        w_allow = (r_y != Y_ZERO);
        w_ny    = r_y - Y_ONE;
      end
      4'b0100: begin
        w_allow = (r_y != Y_MAX);
        w_ny    = r_y + Y_ONE;
      end
      4'b0010: begin
        w_allow = (r_x != X_ZERO);
        w_nx    = r_x - X_ONE;
      end
      4'b0001: begin
        w_allow = (r_x != X_MAX);
        w_nx    = r_x + X_ONE;
      end
      default: begin
        w_allow = 1'b0;
      end
    endcase
  end

  // Game FSM with registered move-bus pulses, position, lives and score.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SPAWN;
      r_key_q     <= 4'b0000;
      r_l         <= 1'b0;
      r_r         <= 1'b0;
      r_u         <= 1'b0;
      r_d         <= 1'b0;
      r_spawn     <= 1'b0;
      r_clr       <= 1'b0;
      r_game_over <= 1'b0;
      r_x         <= X_START;
      r_y         <= Y_START;
      r_score     <= 8'd0;
      r_lives     <= L_INIT;
`ifdef AUTO_REPEAT_EN
      r_rep_act   <= 1'b0;
      r_rep_dir   <= 4'b0000;
      r_rep_cnt   <= REP_ZERO;
`endif
    end else begin
      r_key_q <= w_keys;
      r_l     <= 1'b0;
      r_r     <= 1'b0;
      r_u     <= 1'b0;
      r_d     <= 1'b0;
      r_spawn <= 1'b0;
      r_clr   <= 1'b0;
      case (r_state)
        ST_SPAWN: begin
          r_x <= X_START;
          r_y <= Y_START;
          if (hit) begin
            r_state <= ST_DEAD;
            r_lives <= (r_lives != L_ZERO) ? (r_lives - L_ONE) : r_lives;
          end else begin
            r_spawn <= 1'b1;
            r_state <= ST_READY;
          end
        end
        ST_READY: begin
          if (hit) begin
            r_state <= ST_DEAD;
            r_lives <= (r_lives != L_ZERO) ? (r_lives - L_ONE) : r_lives;
          end else if (w_allow) begin
            r_u <= w_sel[3];
            r_d <= w_sel[2];
            r_l <= w_sel[1];
            r_r <= w_sel[0];
            r_x <= w_nx;
            r_y <= w_ny;
            if (w_sel[3] && (w_ny == Y_ZERO)) begin
              r_state <= ST_WIN;
            end else begin
              r_state <= ST_READY;
            end
          end else begin
            r_state <= ST_READY;
          end
        end
        ST_WIN: begin
          r_clr   <= 1'b1;
          r_score <= (r_score != 8'd255) ? (r_score + 8'd1) : r_score;
          r_state <= ST_SPAWN;
        end
        ST_DEAD: begin
          if (!hit) begin
            if (r_lives != L_ZERO) begin
              r_state <= ST_SPAWN;
            end else begin
              r_state     <= ST_OVER;
              r_game_over <= 1'b1;
            end
          end else begin
            r_state <= ST_DEAD;
          end
        end
        ST_OVER: begin
          r_game_over <= 1'b1;
          r_state     <= ST_OVER;
        end
        default: begin
          r_state <= ST_SPAWN;
        end
      endcase
`ifdef AUTO_REPEAT_EN
      // A fresh edge restarts the repeat; a blocked fresh move leaves it disarmed.
      if ((r_state != ST_READY) || hit) begin
        r_rep_act <= 1'b0;
      end else if (|w_rise) begin
        r_rep_act <= w_allow;
        r_rep_dir <= w_sel;
        r_rep_cnt <= REP_LOAD;
      end else if (!w_rep_held) begin
        r_rep_act <= 1'b0;
      end else if (w_rep_fire) begin
        r_rep_cnt <= REP_LOAD;
      end else if (r_rep_cnt != REP_ZERO) begin
        r_rep_cnt <= r_rep_cnt - REP_ONE;
      end else begin
        r_rep_cnt <= r_rep_cnt;
      end
`endif
    end
  end

  assign L         = r_l;
  assign R         = r_r;
  assign U         = r_u;
  assign D         = r_d;
  assign spawn     = r_spawn;
  assign clr       = r_clr;
  assign frog_x    = r_x;
  assign frog_y    = r_y;
  assign score     = r_score;
  assign lives     = r_lives;
  assign game_over = r_game_over;

endmodule
